// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam int CNT_W = 4;

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: one synchronous write port, one synchronous read port, no reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int IW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [IW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data port responder: stalls for LATENCY+1 cycles, data valid in DONE.
// One access per LATENCY+2 cycles; inputs are ignored while an access is in flight.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wd,
  input  logic        dmem_we,
  input  logic        dmem_re,
  output logic [31:0] dmem_rd,
  output logic        dmem_stall,
  output logic        dmem_misalign,
  output logic [31:0] acc_count
);

  localparam int IW = idx_w(DEPTH_WORDS);

  dmem_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [IW-1:0]    lat_idx;
  logic [31:0]      lat_wd;
  logic             lat_wr;
  logic             req;
  logic             commit;
  logic [IW-1:0]    req_idx;
  logic [IW-1:0]    rd_idx;
  logic [31:0]      arr_rdata;
  logic             unused_addr;

  assign req         = dmem_we | dmem_re;
  assign req_idx     = dmem_addr[IW+1:2];
  assign unused_addr = ^dmem_addr[31:IW+2];

  // Read port tracks the incoming request in IDLE so the word is ready by the first BUSY cycle.
  assign rd_idx = (state == IDLE) ? req_idx : lat_idx;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    dmem_stall = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt  = BUSY;
          dmem_stall = ~reset;
        end
      end
      BUSY: begin
        dmem_stall = ~reset;
        if (cnt == '0) begin
          state_nxt = DONE;
          commit    = ~reset;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      lat_idx       <= '0;
      lat_wd        <= '0;
      lat_wr        <= 1'b0;
      dmem_rd       <= '0;
      dmem_misalign <= 1'b0;
      acc_count     <= '0;
    end else begin
      if (state == IDLE && req) begin
        lat_idx <= req_idx;
        lat_wd  <= dmem_wd;
        lat_wr  <= dmem_we;
        cnt     <= CNT_W'(LATENCY - 1);
        if (dmem_addr[1:0] != 2'b00) dmem_misalign <= 1'b1;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (commit) begin
        dmem_rd   <= lat_wr ? lat_wd : arr_rdata;
        acc_count <= acc_count + 32'd1;
      end
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IW         (IW)
  ) u_array (
    .clk  (clk),
    .we   (commit & lat_wr),
    .waddr(lat_idx),
    .wdata(lat_wd),
    .raddr(rd_idx),
    .rdata(arr_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: LATENCY=2 instance for the main sequence, LATENCY=1 instance for back-to-back.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a_addr, a_wd, a_rd, a_acc;
  logic        a_we, a_re, a_stall, a_mis;
  logic [31:0] b_addr, b_wd, b_rd, b_acc;
  logic        b_we, b_re, b_stall, b_mis;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_a (
    .clk(clk), .reset(reset), .dmem_addr(a_addr), .dmem_wd(a_wd),
    .dmem_we(a_we), .dmem_re(a_re), .dmem_rd(a_rd), .dmem_stall(a_stall),
    .dmem_misalign(a_mis), .acc_count(a_acc)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_b (
    .clk(clk), .reset(reset), .dmem_addr(b_addr), .dmem_wd(b_wd),
    .dmem_we(b_we), .dmem_re(b_re), .dmem_rd(b_rd), .dmem_stall(b_stall),
    .dmem_misalign(b_mis), .acc_count(b_acc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered 1 time unit after a posedge with DUT a in IDLE; leaves the same way.
  task automatic access(input logic we, input logic re, input logic [31:0] addr,
                        input logic [31:0] wd, input logic chg,
                        input logic [31:0] chg_addr, input logic [31:0] chg_wd,
                        output int stalls, output logic [31:0] rd);
    stalls = 0;
    rd     = '0;
    a_we = we; a_re = re; a_addr = addr; a_wd = wd;
    for (int c = 0; c < 12; c++) begin
      if (c == 1) begin
        if (chg) begin
          a_addr = chg_addr;
          a_wd   = chg_wd;
        end else begin
          a_we = 1'b0;
          a_re = 1'b0;
        end
      end
      #1;
      if (a_stall) begin
        stalls++;
        tick();
      end else begin
        rd   = a_rd;
        a_we = 1'b0;
        a_re = 1'b0;
        tick();
        return;
      end
    end
    stalls = 99;
    a_we = 1'b0;
    a_re = 1'b0;
  endtask

  task automatic acc_chk(input string tag, input logic we, input logic re,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd);
    int          st;
    logic [31:0] rd;
    access(we, re, addr, wd, 1'b0, '0, '0, st, rd);
    check({tag, "_stall"}, 32'(st), 32'd3);
    check({tag, "_rd"}, rd, exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          st;
    logic [31:0] rd;
    logic [5:0]  pat;

    reset = 1'b1;
    a_addr = '0; a_wd = '0; a_we = 1'b0; a_re = 1'b0;
    b_addr = '0; b_wd = '0; b_we = 1'b0; b_re = 1'b0;
    tick();
    tick();
    check("rst_stall", {31'd0, a_stall}, 32'd0);
    check("rst_rd", a_rd, 32'd0);
    check("rst_mis", {31'd0, a_mis}, 32'd0);
    check("rst_acc", a_acc, 32'd0);
    reset = 1'b0;
    tick();

    // Write then read back
    acc_chk("wr40", 1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 32'hDEADBEEF);
    acc_chk("rd40", 1'b0, 1'b1, 32'h40, 32'h0, 32'hDEADBEEF);
    check("acc_two", a_acc, 32'd2);

    // Inputs changed during BUSY are ignored
    acc_chk("wr0c_pre", 1'b1, 1'b0, 32'hC, 32'hCCCC, 32'hCCCC);
    access(1'b1, 1'b0, 32'h8, 32'h11, 1'b1, 32'hC, 32'h22, st, rd);
    check("chg_stall", 32'(st), 32'd3);
    check("chg_rd", rd, 32'h11);
    acc_chk("rd08", 1'b0, 1'b1, 32'h8, 32'h0, 32'h11);
    acc_chk("rd0c", 1'b0, 1'b1, 32'hC, 32'h0, 32'hCCCC);

    // Address wrap and misalignment
    acc_chk("wr00", 1'b1, 1'b0, 32'h0, 32'hA0A0, 32'hA0A0);
    acc_chk("rd400", 1'b0, 1'b1, 32'h400, 32'h0, 32'hA0A0);
    check("mis_before", {31'd0, a_mis}, 32'd0);
    a_re = 1'b1; a_addr = 32'h402;
    #1;
    check("mis_c0_stall", {31'd0, a_stall}, 32'd1);
    check("mis_c0", {31'd0, a_mis}, 32'd0);
    tick();
    a_re = 1'b0;
    check("mis_c1", {31'd0, a_mis}, 32'd1);
    tick();
    tick();
    check("mis_done_stall", {31'd0, a_stall}, 32'd0);
    check("mis_rd", a_rd, 32'hA0A0);
    tick();

    // we and re together act as a write
    acc_chk("wrre10", 1'b1, 1'b1, 32'h10, 32'h5A, 32'h5A);
    acc_chk("rd10", 1'b0, 1'b1, 32'h10, 32'h0, 32'h5A);
    check("mis_sticky", {31'd0, a_mis}, 32'd1);

    // Reset during BUSY aborts the store
    acc_chk("wr20_pre", 1'b1, 1'b0, 32'h20, 32'h33, 32'h33);
    a_we = 1'b1; a_addr = 32'h20; a_wd = 32'h77;
    tick();
    a_we = 1'b0;
    reset = 1'b1;
    #1;
    check("rstb_stall", {31'd0, a_stall}, 32'd0);
    tick();
    check("rstb_rd", a_rd, 32'd0);
    check("rstb_acc", a_acc, 32'd0);
    check("rstb_mis", {31'd0, a_mis}, 32'd0);
    reset = 1'b0;
    tick();
    acc_chk("rd20", 1'b0, 1'b1, 32'h20, 32'h0, 32'h33);
    check("rstb_acc_after", a_acc, 32'd1);

    // LATENCY=1, request held high continuously
    b_we = 1'b1; b_addr = 32'h4; b_wd = 32'h1234;
    pat = '0;
    for (int c = 0; c < 6; c++) begin
      #1;
      pat[5-c] = b_stall;
      if (c == 2) begin
        check("b2b_acc1", b_acc, 32'd1);
        check("b2b_rd", b_rd, 32'h1234);
      end
      if (c == 5) check("b2b_acc2", b_acc, 32'd2);
      tick();
    end
    b_we = 1'b0;
    check("b2b_pattern", {26'd0, pat}, {26'd0, 6'b110110});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
